fifo_cmd_master: RTL
====================

// Module: fifo_cmd_master
// PURPOSE
// - Initiator for the 8-entry command-driven FIFO (en/r_w/in/out port). Converts an upstream
//   valid/ready write stream and a downstream valid/ready read stream into FIFO commands.
// - The FIFO port has no status outputs, so this block keeps a shadow occupancy count. It never
//   writes when full or reads when empty, and buffers the one-cycle-late read data.
// - Sits between producer/consumer logic and the FIFO instance; both share clk and reset.
// PARAMETERS
// - DATA_W     32  data width; must equal the FIFO word width
// - DEPTH       8  usable FIFO capacity tracked by the shadow count
// - OBUF_DEPTH  4  read-return buffer entries; power of 2, >= 2
// PORTS
// - clk        in   1                     single clock, all logic on posedge
// - reset      in   1                     synchronous, active-low (0 = reset)
// - wr_valid   in   1                     upstream word available
// - wr_data    in   DATA_W                upstream word
// - wr_ready   out  1                     word accepted when wr_valid&wr_ready
// - drain      in   1                     level; 1 = permit read commands
// - rd_valid   out  1                     buffered read word available
// - rd_data    out  DATA_W                head of read-return buffer
// - rd_ready   in   1                     consumer takes word when rd_valid&rd_ready
// - fifo_en    out  1                     FIFO command strobe, registered
// - fifo_r_w   out  1                     1 = write, 0 = read; registered
// - fifo_in    out  DATA_W                FIFO write data, registered
// - fifo_out   in   DATA_W                FIFO read data, valid cycle after read cmd
// - level      out  $clog2(DEPTH+1)       shadow occupancy
// BEHAVIOUR
// - Reset (reset==0 at posedge): level=0, fifo_en=0, fifo_r_w=0, fifo_in=0, rd_valid=0,
//   buffer/in-flight/arb state cleared. Master assumes FIFO is empty afterwards (FIFO is reset
//   by the same signal). Reset mid-operation discards in-flight reads and buffered data.
// - Per cycle, candidates: W = wr_valid & level<DEPTH;
//   R = drain & level>0 & (buf_cnt+inflight)<OBUF_DEPTH.
// - Arbiter: at most one command per cycle. W only or R only -> grant it. W&R -> alternate via
//   last_grant bit (initially read, so a write goes first); last_grant updates only on a
//   contested grant.
// - wr_ready = W & write granted (combinational). No command -> next cycle fifo_en=0.
// - Grant registers the command: fifo_en=1 and fifo_r_w in the next cycle (t), exactly one
//   cycle. Write: fifo_in=wr_data. Read: fifo_in holds its previous value.
// - level: +1 on write grant, -1 on read grant, updated at the same edge. Never wraps; stays in
//   0..DEPTH.
// - Read pipeline: read cmd visible in cycle t; fifo_out sampled at end of t+1 into the buffer
//   tail; rd_valid=1 from t+2 earliest. inflight counts issued-not-captured reads (0..2).
// - Return buffer: circular, OBUF_DEPTH entries, rd_data = head. Simultaneous capture and pop
//   is allowed at the same edge; buf_cnt is unchanged.
// - Reservation (buf_cnt+inflight) guarantees no overflow. Capture into a full buffer is an
//   error; the assertion fires.
// - Reads are never cancelled by drain falling; already-issued reads still complete.
// - Word order on rd_data = FIFO output order; this block does not reorder.
// CONFIGURATION
// - FIFO_CMD_MASTER_STATS_EN defined: adds ports wr_total, rd_total out 16 each.
//   - wr_total +1 per write grant; rd_total +1 per rd_valid&rd_ready beat.
//   - Both saturate at 16'hFFFF and clear on reset.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - reset=0 for 2 cycles mid-traffic -> next cycle fifo_en=0, rd_valid=0, level=0; wr_ready=1
//   once reset=1 with wr_valid=1.
// - drain=0, push 0x11..0x18 -> 8 fifo_en pulses with r_w=1 and fifo_in in order, level=8;
//   9th word 0x19 sees wr_ready=0.
// - From level 8, drain=1, rd_ready=1 -> 8 read cmds, 8 rd_valid beats, level 8->0; first
//   rd_valid 2 cycles after first read cmd; data matches FIFO model.
// - From level 8, drain=1, rd_ready=0 -> exactly 4 read cmds, then fifo_en stays 0; level=4,
//   rd_valid=1 held. rd_ready=1 resumes reads.
// - level=3, wr_valid=1 and drain=1 continuously, rd_ready=1 -> commands alternate W,R,W,R
//   starting with W; level toggles 4,3,4,3.
// - STATS_EN: 5 writes then 3 pops -> wr_total=5, rd_total=3; counters preset to 16'hFFFE,
//   3 writes -> wr_total=16'hFFFF.

Source files
------------

// File: rtl/fifo_cmd_master.sv
// fifo_cmd_master
//   Command initiator for an 8-entry en/r_w/in/out FIFO that has no status
//   outputs. An upstream valid/ready write stream and a downstream valid/ready
//   read stream are turned into at most one FIFO command per cycle. A shadow
//   occupancy count blocks writes when full and reads when empty. The FIFO
//   returns read data one cycle after the command, so a small return buffer
//   catches that data.
//
//   Optional build macro: FIFO_CMD_MASTER_STATS_EN
//     When defined, the ports wr_total and rd_total are added. They are
//     saturating counts of write grants and of read beats.
//
// Ports
//   clk, reset          single clock; reset is synchronous and active-low
//   wr_valid/wr_data    upstream write stream
//   wr_ready            combinational accept for the write stream
//   drain               level input that permits read commands
//   rd_valid/rd_data    head of the read-return buffer
//   rd_ready            consumer pop
//   fifo_en/r_w/in      registered FIFO command (r_w: 1 = write, 0 = read)
//   fifo_out            FIFO read data, valid the cycle after a read command
//   level               shadow occupancy (0..DEPTH)
//   wr_total/rd_total   (stats build only) saturating 16-bit event counts
module fifo_cmd_master #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic                       drain,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  input  logic                       rd_ready,
  output logic                       fifo_en,
  output logic                       fifo_r_w,
  output logic [DATA_W-1:0]          fifo_in,
  input  logic [DATA_W-1:0]          fifo_out,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef FIFO_CMD_MASTER_STATS_EN
  ,
  output logic [15:0]                wr_total,
  output logic [15:0]                rd_total
`endif
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(OBUF_DEPTH);
  localparam int CNT_W = $clog2(OBUF_DEPTH+1);

  // rd_pipe[0]: a read command is on the FIFO port this cycle.
  // rd_pipe[1]: its data is on fifo_out this cycle and is captured at the next edge.
  logic [1:0]        rd_pipe;
  logic [CNT_W-1:0]  buf_cnt;
  logic [PTR_W-1:0]  head, tail;
  logic [DATA_W-1:0] mem [OBUF_DEPTH];
  logic              last_gnt_w;  // winner of the last contested cycle; 0 = read

  logic [CNT_W:0]    resv;
  logic              cand_w, cand_r, gnt_w, gnt_r, cap, pop;

  always_comb begin
    // Buffer slots already promised, to captured words and to reads in flight.
    resv   = (CNT_W+1)'(buf_cnt) + (CNT_W+1)'(rd_pipe[0]) + (CNT_W+1)'(rd_pipe[1]);
    cand_w = wr_valid && (level < LVL_W'(DEPTH));
    cand_r = drain && (level != '0) && (resv < (CNT_W+1)'(OBUF_DEPTH));
    // When both compete, the side that did not win the last contest goes now.
    gnt_w  = cand_w && (!cand_r || !last_gnt_w);
    gnt_r  = cand_r && !gnt_w;
  end

  assign wr_ready = gnt_w;
  assign rd_valid = (buf_cnt != '0);
  assign rd_data  = mem[head];
  assign pop      = rd_valid && rd_ready;
  assign cap      = rd_pipe[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      fifo_en    <= 1'b0;
      fifo_r_w   <= 1'b0;
      fifo_in    <= '0;
      level      <= '0;
      last_gnt_w <= 1'b0;
      rd_pipe    <= '0;
      buf_cnt    <= '0;
      head       <= '0;
      tail       <= '0;
    end else begin
      fifo_en <= gnt_w || gnt_r;
      if (gnt_w || gnt_r) fifo_r_w <= gnt_w;
      if (gnt_w) fifo_in <= wr_data;
      if (cand_w && cand_r) last_gnt_w <= gnt_w;

      if (gnt_w)      level <= level + LVL_W'(1);
      else if (gnt_r) level <= level - LVL_W'(1);

      rd_pipe <= {rd_pipe[0], gnt_r};

      if (cap) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
      case ({cap, pop})
        2'b10:   buf_cnt <= buf_cnt + CNT_W'(1);
        2'b01:   buf_cnt <= buf_cnt - CNT_W'(1);
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Storage needs no reset; the pointers and the count decide what is valid.
  always_ff @(posedge clk) begin
    if (reset && cap) mem[tail] <= fifo_out;
  end

  // The reservation check should make a capture into a full buffer impossible.
  obuf_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(cap && buf_cnt == CNT_W'(OBUF_DEPTH)));

`ifdef FIFO_CMD_MASTER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_total <= '0;
      rd_total <= '0;
    end else begin
      if (gnt_w && wr_total != 16'hFFFF) wr_total <= wr_total + 16'd1;
      if (pop   && rd_total != 16'hFFFF) rd_total <= rd_total + 16'd1;
    end
  end
`endif

endmodule
